complex_engine: RTL and testbench

COMPLEX_ENGINE -- requirements
Module: complex_engine

---
 rtl/complex_engine_if.sv | 31 +++
 rtl/complex_engine.sv | 214 +++++++++++++++++++++
 tb/tb_complex_engine.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/complex_engine_if.sv
// Job control and sample/result bus of complex_engine.
interface complex_engine_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned AUX_W  = 8,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned ACC_W  = 40
);
  logic                      start;
  logic [LEN_W-1:0]          len;
  logic [1:0]                mode;
  logic signed [DATA_W-1:0]  data_in_1;
  logic [AUX_W-1:0]          data_in_2;
  logic                      data_valid;
  logic                      data_ready;
  logic signed [ACC_W-1:0]   result_1;
  logic [AUX_W+LEN_W-1:0]    result_2;
  logic [2:0]                status;
  logic                      done;
  logic                      busy;
  logic                      overflow;

  modport master (
    output start, len, mode, data_in_1, data_in_2, data_valid,
    input  data_ready, result_1, result_2, status, done, busy, overflow
  );

  modport slave (
    input  start, len, mode, data_in_1, data_in_2, data_valid,
    output data_ready, result_1, result_2, status, done, busy, overflow
  );
endinterface

// File: rtl/complex_engine.sv
// Length-framed multiply-accumulate engine with pipelined products,
// saturating accumulator, side-band unsigned sum and a per-bit tristate pad bus.
module complex_engine #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned AUX_W   = 8,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned ACC_W   = 40,
  parameter int unsigned BIDIR_W = 4,
  parameter int unsigned PIPE    = 2
) (
  input  logic               clk,
  input  logic               rst,
  complex_engine_if.slave    bus,
  input  logic [BIDIR_W-1:0] bidir_out_val,
  input  logic [BIDIR_W-1:0] bidir_oe,
  output logic [BIDIR_W-1:0] bidir_in,
  inout  wire  [BIDIR_W-1:0] bidirectional
);

  localparam int unsigned PROD_A = 2 * DATA_W;
  localparam int unsigned PROD_B = DATA_W + AUX_W + 1;
  localparam int unsigned PROD_W = (PROD_A > PROD_B) ? PROD_A : PROD_B;
  localparam int unsigned SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
  localparam int unsigned R2_W   = AUX_W + LEN_W;
  localparam int unsigned FC_W   = 2;

  localparam logic signed [SUM_W-1:0] SAT_MAX = (SUM_W'(1) <<< (ACC_W - 1)) - SUM_W'(1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = -(SUM_W'(1) <<< (ACC_W - 1));

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_e;

  state_e state_q, state_d;

  logic [LEN_W-1:0]         len_q, len_d, cnt_q, cnt_d;
  logic [1:0]               mode_q, mode_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [R2_W-1:0]          r2_q, r2_d;
  logic                     ovf_q, ovf_d;
  logic [FC_W-1:0]          flush_q, flush_d;
  logic [2:0]               status_q, status_d;
  logic                     busy_q, busy_d, done_q, done_d, ready_q, ready_d;
  logic signed [PROD_W-1:0] pipe_q [PIPE];
  logic                     pv_q   [PIPE];
  logic [BIDIR_W-1:0]       sync1_q, sync2_q;

  logic                     start_fire, acc_fire;
  logic signed [PROD_W-1:0] a_ext, b_ext, prod_c;
  logic signed [SUM_W-1:0]  sum_c;

  assign start_fire = bus.start && (state_q == S_IDLE);
  assign acc_fire   = bus.data_valid && ready_q;

  // Product of the current sample, selected by the latched mode.
  always_comb begin
    a_ext = PROD_W'(bus.data_in_1);
    b_ext = PROD_W'($signed({1'b0, bus.data_in_2}));
    case (mode_q)
      2'd1:    prod_c = a_ext * b_ext;
      2'd2:    prod_c = a_ext;
      default: prod_c = a_ext * a_ext;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = (bus.len == '0) ? S_DONE : S_RUN;
      S_RUN:   if (acc_fire && ((cnt_q + LEN_W'(1)) == len_q)) state_d = S_FLUSH;
      S_FLUSH: if (flush_q == FC_W'(PIPE - 1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode for the upcoming state; IDLE keeps the last status (000 or 111).
  always_comb begin
    status_d = status_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    ready_d  = 1'b0;
    case (state_d)
      S_RUN: begin
        status_d = 3'b001;
        busy_d   = 1'b1;
        ready_d  = (cnt_d < len_d);
      end
      S_FLUSH: begin
        status_d = 3'b010;
        busy_d   = 1'b1;
      end
      S_DONE: begin
        status_d = 3'b111;
        busy_d   = 1'b1;
        done_d   = 1'b1;
      end
      default: status_d = status_q;
    endcase
  end

  // Job parameters, sample counter and saturating accumulation.
  always_comb begin
    len_d   = len_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    r2_d    = r2_q;
    ovf_d   = ovf_q;
    flush_d = (state_q == S_FLUSH) ? flush_q + FC_W'(1) : '0;
    sum_c   = SUM_W'(acc_q) + SUM_W'(pipe_q[PIPE-1]);
    if (start_fire) begin
      len_d  = bus.len;
      mode_d = bus.mode;
      cnt_d  = '0;
      acc_d  = '0;
      r2_d   = '0;
      ovf_d  = 1'b0;
    end else begin
      if (acc_fire) begin
        cnt_d = cnt_q + LEN_W'(1);
        r2_d  = r2_q + R2_W'(bus.data_in_2);
      end
      if (pv_q[PIPE-1]) begin
        if (sum_c > SAT_MAX) begin
          acc_d = ACC_W'(SAT_MAX);
          ovf_d = 1'b1;
        end else if (sum_c < SAT_MIN) begin
          acc_d = ACC_W'(SAT_MIN);
          ovf_d = 1'b1;
        end else begin
          acc_d = ACC_W'(sum_c);
        end
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= '0;
      mode_q   <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      r2_q     <= '0;
      ovf_q    <= 1'b0;
      flush_q  <= '0;
      status_q <= 3'b000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      len_q    <= len_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      r2_q     <= r2_d;
      ovf_q    <= ovf_d;
      flush_q  <= flush_d;
      status_q <= status_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  // Product pipeline; the valid bit marks stages holding an accepted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(PIPE); i++) begin
        pipe_q[i] <= '0;
        pv_q[i]   <= 1'b0;
      end
    end else begin
      pipe_q[0] <= prod_c;
      pv_q[0]   <= acc_fire;
      for (int i = 1; i < int'(PIPE); i++) begin
        pipe_q[i] <= pipe_q[i-1];
        pv_q[i]   <= pv_q[i-1];
      end
    end
  end

  // Two-flop capture of the pad bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bidirectional;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit pad drivers.
  for (genvar gi = 0; gi < int'(BIDIR_W); gi++) begin : g_pad
    assign bidirectional[gi] = bidir_oe[gi] ? bidir_out_val[gi] : 1'bz;
  end

  assign bus.data_ready = ready_q;
  assign bus.result_1   = acc_q;
  assign bus.result_2   = r2_q;
  assign bus.status     = status_q;
  assign bus.done       = done_q;
  assign bus.busy       = busy_q;
  assign bus.overflow   = ovf_q;
  assign bidir_in       = sync2_q;

endmodule

// File: tb/tb_complex_engine.sv
// Randomized job bench for complex_engine against an arithmetic reference model.
module tb_complex_engine;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned AUX_W   = 8;
  localparam int unsigned LEN_W   = 8;
  localparam int unsigned ACC_W   = 32;
  localparam int unsigned BIDIR_W = 4;
  localparam int unsigned PIPE    = 2;

  localparam longint MAXV = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (ACC_W - 1));

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  complex_engine_if #(.DATA_W(DATA_W), .AUX_W(AUX_W), .LEN_W(LEN_W), .ACC_W(ACC_W)) bus ();

  logic [BIDIR_W-1:0] pad_val, pad_oe, bidir_in, tb_en, tb_val;
  wire  [BIDIR_W-1:0] pad;

  for (genvar gi = 0; gi < int'(BIDIR_W); gi++) begin : g_tb_pad
    assign pad[gi] = tb_en[gi] ? tb_val[gi] : 1'bz;
  end

  complex_engine #(
    .DATA_W(DATA_W), .AUX_W(AUX_W), .LEN_W(LEN_W), .ACC_W(ACC_W),
    .BIDIR_W(BIDIR_W), .PIPE(PIPE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .bidir_out_val(pad_val),
    .bidir_oe(pad_oe),
    .bidir_in(bidir_in),
    .bidirectional(pad)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int a_arr [256];
  int b_arr [256];

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drives one job of n samples from a_arr/b_arr and checks it against the model.
  task automatic run_job(input int n, input logic [1:0] md, input int gap_fixed,
                         input int gap_rand, input bit junk, input bit poke);
    longint acc = 0;
    longint r2  = 0;
    longint p;
    bit     ovf = 1'b0;
    int     k   = 0;
    int     idle_left = 0;
    bit     v;
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = LEN_W'(n);
    bus.mode  = md;
    bus.data_valid = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    if (n > 0) begin
      check("r1_cleared", bus.result_1, 0);
      check("ovf_cleared", bus.overflow, 0);
      while (k < n) begin
        check("ready_run", bus.data_ready, 1);
        check("status_run", bus.status, 1);
        if (gap_fixed > 0) v = (idle_left == 0);
        else               v = ($urandom_range(0, gap_rand) == 0);
        bus.data_valid = v;
        bus.data_in_1  = v ? DATA_W'(a_arr[k]) : DATA_W'($urandom);
        bus.data_in_2  = v ? AUX_W'(b_arr[k]) : AUX_W'($urandom);
        if (poke && k == 0) begin
          bus.start = 1'b1;
          bus.len   = '0;
        end
        @(negedge clk);
        bus.start = 1'b0;
        if (v) begin
          case (md)
            2'd1:    p = longint'(a_arr[k]) * longint'(b_arr[k]);
            2'd2:    p = longint'(a_arr[k]);
            default: p = longint'(a_arr[k]) * longint'(a_arr[k]);
          endcase
          acc = acc + p;
          if (acc > MAXV) begin acc = MAXV; ovf = 1'b1; end
          else if (acc < MINV) begin acc = MINV; ovf = 1'b1; end
          r2 = r2 + longint'(b_arr[k]);
          k++;
          idle_left = gap_fixed;
        end else if (idle_left > 0) begin
          idle_left--;
        end
      end
      bus.data_valid = junk;
      bus.data_in_1  = DATA_W'($urandom);
      bus.data_in_2  = AUX_W'($urandom);
      for (int i = 0; i < int'(PIPE); i++) begin
        check("status_flush", bus.status, 2);
        check("done_flush", bus.done, 0);
        check("ready_flush", bus.data_ready, 0);
        @(negedge clk);
      end
    end
    check("done_pulse", bus.done, 1);
    check("status_done", bus.status, 7);
    check("busy_done", bus.busy, 1);
    check("result_1", bus.result_1, acc);
    check("result_2", bus.result_2, r2);
    check("overflow", bus.overflow, longint'(ovf));
    @(negedge clk);
    bus.data_valid = 1'b0;
    check("done_drop", bus.done, 0);
    check("busy_idle", bus.busy, 0);
    check("status_idle", bus.status, 7);
    check("r1_held", bus.result_1, acc);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.start = 1'b0; bus.len = '0; bus.mode = '0;
    bus.data_in_1 = '0; bus.data_in_2 = '0; bus.data_valid = 1'b0;
    pad_oe = '0; pad_val = '0; tb_en = '1; tb_val = '0;
    repeat (3) @(negedge clk);
    check("rst_status", bus.status, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_ready", bus.data_ready, 0);
    check("rst_r1", bus.result_1, 0);
    check("rst_r2", bus.result_2, 0);
    check("rst_ovf", bus.overflow, 0);
    rst = 1'b0;

    // Basic square-accumulate job.
    a_arr[0] = 3; a_arr[1] = -4; a_arr[2] = 5;
    b_arr[0] = 10; b_arr[1] = 20; b_arr[2] = 30;
    run_job(3, 2'd0, 0, 0, 1'b0, 1'b0);
    check("dir_sq_r1", bus.result_1, 50);
    check("dir_sq_r2", bus.result_2, 60);

    // Positive saturation, then a fresh start must clear overflow.
    for (int i = 0; i < 3; i++) begin a_arr[i] = -32768; b_arr[i] = 0; end
    run_job(3, 2'd0, 0, 0, 1'b0, 1'b0);
    check("dir_sat_r1", bus.result_1, 2147483647);
    check("dir_sat_ovf", bus.overflow, 1);

    // Signed-by-unsigned with fixed 3-cycle valid gaps.
    a_arr[0] = -7; a_arr[1] = -7; b_arr[0] = 200; b_arr[1] = 100;
    run_job(2, 2'd1, 3, 0, 1'b1, 1'b0);
    check("dir_mul_r1", bus.result_1, -2100);
    check("dir_mul_r2", bus.result_2, 300);
    check("dir_ovf_cleared", bus.overflow, 0);

    // Zero-length job, and a start pulse while running.
    run_job(0, 2'd0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin a_arr[i] = i + 1; b_arr[i] = 1; end
    run_job(4, 2'd2, 0, 1, 1'b1, 1'b1);

    // Longest job: passthrough mode with maximum aux values.
    for (int i = 0; i < 255; i++) begin
      a_arr[i] = int'($urandom_range(0, 65535)) - 32768;
      b_arr[i] = 255;
    end
    run_job(255, 2'd2, 0, 0, 1'b0, 1'b0);

    // Randomized jobs.
    for (int j = 0; j < 24; j++) begin
      n = int'($urandom_range(1, 12));
      for (int i = 0; i < n; i++) begin
        a_arr[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) - 32768
                                               : int'($urandom_range(0, 200)) - 100;
        b_arr[i] = int'($urandom_range(0, 255));
      end
      run_job(n, 2'($urandom_range(0, 3)), 0, int'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a job aborts it.
    @(negedge clk);
    bus.start = 1'b1; bus.len = LEN_W'(4); bus.mode = 2'd0;
    @(negedge clk);
    bus.start = 1'b0; bus.data_valid = 1'b1; bus.data_in_1 = 16'sd100; bus.data_in_2 = 8'd9;
    @(negedge clk);
    bus.data_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("abort_status", bus.status, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_r1", bus.result_1, 0);
    check("abort_r2", bus.result_2, 0);
    check("abort_ready", bus.data_ready, 0);
    rst = 1'b0;
    for (int i = 0; i < int'(PIPE) + 2; i++) begin
      check("abort_no_done", bus.done, 0);
      check("abort_r1_quiet", bus.result_1, 0);
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      a_arr[i] = int'($urandom_range(0, 2000)) - 1000;
      b_arr[i] = int'($urandom_range(0, 255));
    end
    run_job(5, 2'd3, 0, 1, 1'b0, 1'b0);

    // Pad bus: DUT drives bits 0,2; bench drives bits 1,3.
    check("pad_initial_in", bidir_in, 0);
    pad_oe = 4'b0101; pad_val = 4'b1111;
    tb_en  = 4'b1010; tb_val  = 4'b0010;
    #1;
    check("pad_value", pad, 4'b0111);
    @(negedge clk);
    check("pad_in_latency", bidir_in, 0);
    @(negedge clk);
    check("pad_in_sync", bidir_in, 4'b0111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
